// File: rtl/simple_cnn.sv
// 5x5 image, 3x3 fixed-kernel convolution with ReLU and argmax.
// One feature-map position per cycle; result registered on FINISH exit.
module simple_cnn (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         START,
  input  logic         X,
  input  logic         Y,
  input  logic [199:0] IMGIN,
  output logic         DONE,
  output logic [3:0]   OUT
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [199:0]   img_q, img_d;
  logic [1:0]     f_q, f_d;
  logic [3:0]     p_q, p_d;
  logic [12:0]    best_q, best_d;
  logic [3:0]     idx_q, idx_d;
  logic           done_q, done_d;
  logic [3:0]     out_q, out_d;

  logic [7:0]     pix [5][5];
  logic [2:0]     wi, wj;
  logic signed [13:0] acc;
  logic [12:0]    act;

  function automatic logic signed [3:0] kw(
    input logic [1:0] f,
    input int         k,
    input int         l
  );
    kw = 4'sd0;
    case (f)
      2'd0: kw = (l == 0) ? -4'sd1 : (l == 2) ? 4'sd1 : 4'sd0;
      2'd1: kw = (k == 0) ? -4'sd1 : (k == 2) ? 4'sd1 : 4'sd0;
      2'd2: begin
        if (k == 1 && l == 1)      kw = 4'sd4;
        else if (k == 1 || l == 1) kw = -4'sd1;
        else                       kw = 4'sd0;
      end
      default: kw = 4'sd1;
    endcase
  endfunction

  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pix[r][c] = img_q[(r*5+c)*8 +: 8];
  end

  // p = i*3 + j, window top-left at (i,j)
  always_comb begin
    wi = 3'd0;
    wj = 3'd0;
    case (p_q)
      4'd1: begin wi = 3'd0; wj = 3'd1; end
      4'd2: begin wi = 3'd0; wj = 3'd2; end
      4'd3: begin wi = 3'd1; wj = 3'd0; end
      4'd4: begin wi = 3'd1; wj = 3'd1; end
      4'd5: begin wi = 3'd1; wj = 3'd2; end
      4'd6: begin wi = 3'd2; wj = 3'd0; end
      4'd7: begin wi = 3'd2; wj = 3'd1; end
      4'd8: begin wi = 3'd2; wj = 3'd2; end
      default: begin wi = 3'd0; wj = 3'd0; end
    endcase
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++)
        acc = acc + $signed({6'd0, pix[wi + 3'(k)][wj + 3'(l)]})
                  * 14'(kw(f_q, k, l));
  end

  assign act = acc[13] ? 13'd0 : acc[12:0];

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    f_d     = f_q;
    p_d     = p_q;
    best_d  = best_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          img_d   = IMGIN;
          f_d     = {Y, X};
          best_d  = '0;
          idx_d   = '0;
          p_d     = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (act > best_q) begin
          best_d = act;
          idx_d  = p_q;
        end
        if (p_q == 4'd8) state_d = FINISH;
        else             p_d = p_q + 4'd1;
      end
      FINISH: begin
        done_d  = 1'b1;
        out_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      img_q   <= '0;
      f_q     <= '0;
      p_q     <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      f_q     <= f_d;
      p_q     <= p_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign DONE = done_q;
  assign OUT  = out_q;

endmodule

// File: tb/tb_simple_cnn.sv
// Directed vector bench for simple_cnn: results, latency, and
// multi-cycle corner cases (re-START, mid-run reset, held START).
module tb_simple_cnn;

  logic         CLK;
  logic         nRST;
  logic         START;
  logic         X;
  logic         Y;
  logic [199:0] IMGIN;
  logic         DONE;
  logic [3:0]   OUT;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_out;

  simple_cnn dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .START (START),
    .X     (X),
    .Y     (Y),
    .IMGIN (IMGIN),
    .DONE  (DONE),
    .OUT   (OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string        name;
    logic [1:0]   f;
    logic [199:0] img;
    logic [3:0]   exp_out;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [199:0] setpx(
    input logic [199:0] im, input int r, input int c, input logic [7:0] v
  );
    logic [199:0] t;
    t = im;
    t[(r*5+c)*8 +: 8] = v;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(
    input string nm, input logic [1:0] f,
    input logic [199:0] img, input logic [3:0] exp
  );
    int early;
    early = 0;
    {Y, X} = f;
    IMGIN  = img;
    START  = 1'b1;
    step();
    START  = 1'b0;
    IMGIN  = ~img;
    {Y, X} = ~f;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (DONE) early++;
      if (k == 5) chk({nm, "_hold"}, OUT, last_out);
    end
    chk({nm, "_early_done"}, early, 0);
    step();
    chk({nm, "_done"}, DONE, 1);
    chk({nm, "_out"}, OUT, exp);
    step();
    chk({nm, "_done_pulse"}, DONE, 0);
    last_out = exp;
  endtask

  initial begin
    logic [199:0] im;
    int cnt;
    int first_t;
    int second_t;

    im = '0;
    vecs[0] = '{"zero_f1", 2'b01, im, 4'd0};
    vecs[1] = '{"box_px44", 2'b11, setpx(im, 4, 4, 8'd255), 4'd8};
    im = '0;
    for (int r = 0; r < 5; r++) begin
      im = setpx(im, r, 3, 8'd200);
      im = setpx(im, r, 4, 8'd200);
    end
    vecs[2] = '{"vedge_tie", 2'b00, im, 4'd1};
    im = '0;
    vecs[3] = '{"lap_center", 2'b10, setpx(im, 2, 2, 8'd100), 4'd4};
    im = '1;
    vecs[4] = '{"box_full", 2'b11, im, 4'd0};
    im = '0;
    for (int c = 0; c < 5; c++) begin
      im = setpx(im, 3, c, 8'd50);
      im = setpx(im, 4, c, 8'd50);
    end
    vecs[5] = '{"hedge_tie", 2'b01, im, 4'd3};
    im = setpx(200'd0, 3, 1, 8'd10);
    im = setpx(im, 1, 3, 8'd20);
    vecs[6] = '{"lap_two", 2'b10, im, 4'd2};
    im = setpx(200'd0, 0, 0, 8'd7);
    im = setpx(im, 2, 4, 8'd9);
    vecs[7] = '{"vedge_relu", 2'b00, im, 4'd8 - 4'd6};

    START = 1'b0;
    X = 1'b0;
    Y = 1'b0;
    IMGIN = '0;
    nRST = 1'b1;
    last_out = 4'd0;
    step();
    step();
    nRST = 1'b0;
    chk("reset_done", DONE, 0);
    chk("reset_out", OUT, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (DONE) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    for (int v = 0; v < 8; v++)
      run(vecs[v].name, vecs[v].f, vecs[v].img, vecs[v].exp_out);

    // START re-pulsed during CONV with a different image
    {Y, X} = 2'b11;
    IMGIN  = setpx(200'd0, 4, 4, 8'd255);
    START  = 1'b1;
    step();
    START  = 1'b0;
    cnt = 0;
    first_t = -1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        START  = 1'b1;
        {Y, X} = 2'b11;
        IMGIN  = setpx(200'd0, 0, 0, 8'd255);
      end
      if (k == 4) START = 1'b0;
      step();
      if (DONE) begin
        cnt++;
        if (first_t < 0) first_t = k;
      end
    end
    chk("restart_count", cnt, 1);
    chk("restart_time", first_t, 10);
    chk("restart_out", OUT, 8);

    // reset at cycle 5 of CONV aborts the run
    {Y, X} = 2'b11;
    IMGIN  = setpx(200'd0, 0, 0, 8'd255);
    START  = 1'b1;
    step();
    START  = 1'b0;
    for (int k = 0; k < 4; k++) step();
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    chk("abort_out", OUT, 0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (DONE) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    last_out = 4'd0;
    run("after_abort", 2'b10, setpx(200'd0, 2, 2, 8'd100), 4'd4);

    // reset has priority over START
    nRST  = 1'b1;
    START = 1'b1;
    step();
    nRST  = 1'b0;
    START = 1'b0;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (DONE) cnt++;
    end
    chk("rst_prio_no_done", cnt, 0);
    chk("rst_prio_out", OUT, 0);

    // START held high: back-to-back runs 11 cycles apart
    {Y, X} = 2'b11;
    IMGIN  = setpx(200'd0, 4, 4, 8'd255);
    START  = 1'b1;
    step();
    cnt = 0;
    first_t = -1;
    second_t = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (DONE) begin
        cnt++;
        if (first_t < 0) first_t = k;
        else if (second_t < 0) second_t = k;
      end
    end
    START = 1'b0;
    chk("held_first", first_t, 10);
    chk("held_second", second_t, 21);
    chk("held_out", OUT, 8);
    for (int k = 0; k < 12; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
